seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed 7-segment display driver for the century clock. Sits directly downstream of the per-digit `counter_09` stages. It takes their packed active-low segment patterns and scans them one digit at a time onto a single shared segment bus with active-low digit enables. Each digit slot begins with an anti-ghosting blank gap, and the segment pattern is snapshotted at slot start so a counter update mid-slot never tears.

## Interface
Parameters:
- NUM_DIGITS, default 8: number of digits scanned (2..16).
- REFRESH_DIV, default 50000: clk cycles per digit slot (≥ 2).
- BLANK_CYCLES, default 500: blank cycles at the start of each slot (0 ≤ BLANK_CYCLES < REFRESH_DIV).
- BLINK_FRAMES, default 64: full frames per blink half-period (≥ 1); only used with SEG_SCAN_BLINK_EN.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  display on; low forces all digits dark.
- seg_in  input  7*NUM_DIGITS  packed active-low patterns; digit i at [7i+6:7i], digit 0 rightmost.
- seg_out  output  7  active-low segment bus (bit0=a … bit6=g).
- an  output  NUM_DIGITS  active-low digit enables, at most one low.
- digit_idx  output  $clog2(NUM_DIGITS)  digit currently owning the slot.
- frame_start  output  1  one-cycle pulse in the first cycle of each digit-0 slot.
- blink_mask  input  NUM_DIGITS  present only with SEG_SCAN_BLINK_EN; bit i makes digit i blink.

## Operation
- State machine has three states: OFF, BLANK, DRIVE. Reset enters OFF.
- OFF:
  - an = all 1, seg_out = 7'h7F, cnt = 0, digit_idx = 0.
  - Leaves to BLANK when enable is sampled high. On that same edge, snapshot ← seg_in[digit 0] and frame_start pulses.
- BLANK:
  - an = all 1, seg_out = 7'h7F.
  - cnt increments each cycle.
  - When cnt == BLANK_CYCLES-1, go to DRIVE.
  - If BLANK_CYCLES = 0, BLANK is skipped: slot entry goes straight to DRIVE.
- DRIVE:
  - an[digit_idx] = 0, seg_out = snapshot.
  - When cnt == REFRESH_DIV-1, the next slot starts:
    - cnt ← 0.
    - digit_idx ← digit_idx+1, wrapping from NUM_DIGITS-1 to 0.
    - snapshot ← seg_in of the new digit.
    - state ← BLANK (or DRIVE if BLANK_CYCLES = 0).
  - The wrap to 0 asserts frame_start for that slot's first cycle.
- enable sampled low in any state: OFF on the next cycle, all counters cleared. Re-enable always restarts at digit 0 with a full slot.
- seg_in changes mid-slot are ignored until the next slot entry.
- NUM_DIGITS not a power of two: digit_idx wraps explicitly at NUM_DIGITS-1 and never takes an unused value.

## Timing
- All outputs registered. Reset values:
  - seg_out = 7'h7F
  - an = all 1
  - digit_idx = 0
  - frame_start = 0
  - internal state OFF
- Async reset takes effect immediately, mid-slot included. Release is synchronous to the next clk edge.
- enable → first BLANK cycle on outputs: 1 clk. enable low → dark: 1 clk.
- Each slot is exactly REFRESH_DIV cycles: BLANK_CYCLES dark, then REFRESH_DIV-BLANK_CYCLES driven.
- Frame period is NUM_DIGITS·REFRESH_DIV cycles.
- Exactly one frame_start pulse per frame, coincident with the first cycle of the digit-0 slot (including the enable restart).

## Configuration
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds the blink_mask port and a frame counter modulo BLINK_FRAMES, advanced on frame_start. The counter toggles blink_phase at each wrap; blink_phase resets to 0.
  - While blink_phase = 1 and blink_mask[digit_idx] = 1, DRIVE behaves as BLANK for that digit: an stays high, seg_out = 7'h7F.
  - Slot timing is unchanged.
- Undefined: no blink_mask port, no frame counter; every digit is driven in every DRIVE window.

## Structure
- Package seg_scan_pkg: state enum (OFF, BLANK, DRIVE), SEG_OFF = 7'h7F, and a function extracting digit i from the packed bus.
- One sub-module, scan_slot_timer. It holds the cnt counter, emits slot_end (cnt == REFRESH_DIV-1) and blank_end (cnt == BLANK_CYCLES-1), and clears on a sync clear input.
- The top module holds the FSM, digit_idx, the snapshot register, frame_start, and the optional blink logic.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset: reset high mid-DRIVE → an=4'b1111, seg_out=7'h7F, digit_idx=0 immediately, without waiting for a clk edge.
- Scan order: seg_in = {7'h40,7'h79,7'h24,7'h30}, enable=1 → per slot: 2 dark cycles, then 6 cycles with an=1110/seg=7'h30, 1101/7'h24, 1011/7'h79, 0111/7'h40. Then wrap to 1110, with frame_start every 32 cycles.
- Snapshot: change seg_in[digit 1] in cycle 4 of the digit-1 slot → seg_out holds the old value until the slot ends; the new value appears on the next digit-1 slot.
- Enable drop: enable=0 in the digit-2 DRIVE window → dark next cycle. Re-enable → frame_start pulses and digit 0 restarts with 2 blank cycles.
- BLANK_CYCLES=0 variant: an never all 1 while enabled; each digit is driven for all 8 cycles.
- Blink (with SEG_SCAN_BLINK_EN): blink_mask=4'b0100 → digit 2 is driven in frames 0–1, dark in frames 2–3, and driven again in frames 4–5. Other digits are unaffected.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Holds the scan state enum, the dark segment pattern and a digit extractor.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        OFF,
        BLANK,
        DRIVE
    } scan_state_e;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         MAX_DIGITS = 16;
    localparam int         EXT_W      = 7 * MAX_DIGITS;

    // Pick digit idx out of a packed bus, digit 0 in the low bits.
    function automatic logic [6:0] seg_digit(
        input logic [EXT_W-1:0] bus,
        input int unsigned      idx
    );
        return bus[7*idx +: 7];
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_slot_timer.sv
// Slot cycle counter for the segment scanner.
// Ports: clk, reset (async, high), clear (sync), slot_end, blank_end.
module scan_slot_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic slot_end,
    output logic blank_end
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BE = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = clear ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
    // With no blank gap the BLANK state is never entered.
    assign blank_end = (BLANK_CYCLES != 0) && (cnt_q == CW'(BE));

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: one digit per slot, blank gap first.
// Ports: clk, reset, enable, seg_in, [blink_mask], seg_out, an, digit_idx,
// frame_start. Optional blink support under macro SEG_SCAN_BLINK_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7*NUM_DIGITS-1:0]       seg_in,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int          IW   = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam scan_state_e ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    scan_state_e state_q, state_d;
    logic [IW-1:0] digit_q, digit_d;
    logic [6:0] snap_q, snap_d;
    logic [6:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic fs_q, fs_d;
    logic tmr_clear, slot_end, blank_end, blink_dark;
    logic [EXT_W-1:0] seg_ext;

    assign seg_ext = EXT_W'(seg_in);

    scan_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .slot_end (slot_end),
        .blank_end(blank_end)
    );

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        snap_d    = snap_q;
        fs_d      = 1'b0;
        tmr_clear = 1'b0;
        if (!enable) begin
            state_d   = OFF;
            digit_d   = '0;
            tmr_clear = 1'b1;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d   = ENTRY;
                    digit_d   = '0;
                    snap_d    = seg_digit(seg_ext, 0);
                    fs_d      = 1'b1;
                    tmr_clear = 1'b1;
                end
                BLANK: begin
                    if (blank_end) state_d = DRIVE;
                end
                DRIVE: begin
                    if (slot_end) begin
                        tmr_clear = 1'b1;
                        state_d   = ENTRY;
                        digit_d   = (digit_q == LAST) ? '0 : digit_q + 1'b1;
                        snap_d    = seg_digit(seg_ext, int'(digit_d));
                        fs_d      = (digit_q == LAST);
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up
    // with the state they describe.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == DRIVE && !blink_dark) begin
            an_d[digit_d] = 1'b0;
            seg_d         = snap_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
            digit_q <= '0;
            snap_q  <= SEG_OFF;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic phase_q, phase_d;

    // Frame counter advances on wrap pulses only; a restart from OFF
    // begins frame 0 in the visible phase.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (state_d == OFF) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (fs_d && state_q != OFF) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_dark = phase_d & blink_mask[digit_d];
`else
    // Blink support absent; parameter kept for a uniform interface.
    assign blink_dark = 1'b0 & (|BLINK_FRAMES);
`endif

    assign seg_out     = seg_q;
    assign an          = an_q;
    assign digit_idx   = digit_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized self-checking bench for seg_scan_mux against a slot-arithmetic model.
// Second instance covers the zero-blank-gap variant.
module tb_seg_scan_mux;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [27:0] seg_in;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  seg_out, seg_b;
    logic [3:0]  an, an_b;
    logic [1:0]  digit_idx, idx_b;
    logic        frame_start, fs_b;

    int t = -1;
    logic [6:0] snap = 7'h7F;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out(seg_out), .an(an), .digit_idx(digit_idx),
        .frame_start(frame_start)
    );

    seg_scan_mux #(
        .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(0), .BLINK_FRAMES(BF)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out(seg_b), .an(an_b), .digit_idx(idx_b),
        .frame_start(fs_b)
    );

    // Expected {an, seg, idx, frame_start} at cycle tt since enable.
    function automatic logic [13:0] model(int tt, int bc, logic [6:0] sn);
        logic [3:0] a;
        logic [6:0] s;
        logic dark;
        int pos, d;
        a = 4'hF;
        s = 7'h7F;
        if (tt < 0) return {a, s, 2'd0, 1'b0};
        pos  = tt % RD;
        d    = (tt / RD) % N;
        dark = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        dark = (((tt / (N * RD)) / BF) % 2 == 1) && blink_mask[d];
`endif
        if (pos >= bc && !dark) begin
            a[d] = 1'b0;
            s    = sn;
        end
        return {a, s, 2'(d), 1'((tt % (N * RD)) == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (enable && !reset) t = t + 1;
        else t = -1;
        if (t >= 0 && t % RD == 0) snap = seg_in[7*((t/RD)%N) +: 7];
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        seg_in = '0;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0000;
`endif
        #1;
        checks++;
        if ({an, seg_out, digit_idx, frame_start} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_init got=%h exp=%h",
                     {an, seg_out, digit_idx, frame_start}, {4'hF, 7'h7F, 2'd0, 1'b0});
        end
        #20 reset = 1'b0;
        enable = 1'b1;
        seg_in = $urandom;
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL pre_reset t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({an, seg_out, digit_idx, frame_start} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h",
                     {an, seg_out, digit_idx, frame_start}, {4'hF, 7'h7F, 2'd0, 1'b0});
        end
        enable = 1'b0;
        #2 reset = 1'b0;
        t = -1;
        tick();
        checks++;
        if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
            errors++;
            $display("FAIL post_reset got=%h exp=%h",
                     {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
        end
    endtask

    task automatic test_scan();
        seg_in = {7'h40, 7'h79, 7'h24, 7'h30};
        enable = 1'b1;
        for (int i = 0; i < 72; i++) begin
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL scan t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 96; i++) begin
            seg_in = {$urandom, $urandom};
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL snapshot t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
        end
    endtask

    task automatic test_enable_drop();
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            seg_in = {$urandom, $urandom};
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL drop_pre t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
            if ((t / RD) % N == 2 && t % RD == 4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drop_find got=none exp=digit2_drive");
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL drop_dark got=%h exp=%h",
                         {an, seg_out, digit_idx, frame_start}, {4'hF, 7'h7F, 2'd0, 1'b0});
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL restart t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
            seg_in = {$urandom, $urandom};
        end
    endtask

    task automatic test_blank0();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({an_b, seg_b, idx_b, fs_b} !== model(t, 0, snap) || an_b == 4'hF) begin
                errors++;
                $display("FAIL blank0 t=%0d got=%h exp=%h",
                         t, {an_b, seg_b, idx_b, fs_b}, model(t, 0, snap));
            end
            seg_in = {$urandom, $urandom};
        end
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        enable = 1'b0;
        tick();
        blink_mask = 4'b0100;
        enable = 1'b1;
        for (int i = 0; i < 6 * N * RD; i++) begin
            tick();
            checks++;
            if ({an, seg_out, digit_idx, frame_start} !== model(t, BC, snap)) begin
                errors++;
                $display("FAIL blink t=%0d got=%h exp=%h",
                         t, {an, seg_out, digit_idx, frame_start}, model(t, BC, snap));
            end
            seg_in = {$urandom, $urandom};
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_enable_drop();
        test_blank0();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
